// File: rtl/eth_frame_gen_pkg.sv
// Shared types and constants for the Ethernet frame generator.
//   state_t      : frame generator FSM states
//   frame_cfg_t  : configuration latched at each frame start
//   HDR_LEN      : bytes in the Ethernet header (dst, src, EtherType)
//   PRBS_SEED    : PRBS-7 state loaded at the start of every frame
//   PRBS_TAPS    : feedback taps for x^7 + x^6 + 1
//   hdr_byte()   : picks header byte n, most significant byte first
//   clamp_len()  : clamps a requested payload length into [1, max_len]
package eth_frame_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_GAP
  } state_t;

  localparam int HDR_LEN = 14;

  localparam logic [6:0] PRBS_SEED = 7'h7F;
  localparam logic [6:0] PRBS_TAPS = 7'b110_0000;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] ethertype;
    logic [15:0] len;
  } frame_cfg_t;

  function automatic logic [7:0] hdr_byte(input frame_cfg_t cfg, input logic [3:0] idx);
    logic [111:0] hdr;
    hdr = {cfg.dst, cfg.src, cfg.ethertype};
    return hdr[(111 - 8 * int'(idx)) -: 8];
  endfunction

  function automatic logic [15:0] clamp_len(input logic [15:0] len, input int unsigned max_len);
    if (len == 16'd0) return 16'd1;
    if (32'(len) > max_len) return 16'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/eth_prbs7_byte.sv
// PRBS-7 (x^7 + x^6 + 1) byte source.
// byte_out is the next 8 generator bits, first bit in bit 7, computed from
// the current LFSR state. seed_load reloads PRBS_SEED; advance steps the
// LFSR by 8 bits so byte_out moves on to the following byte.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   seed_load   : reload the seed (has priority over advance)
//   advance     : consume byte_out
//   byte_out    : current PRBS byte
module eth_prbs7_byte
  import eth_frame_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seed_load,
  input  logic       advance,
  output logic [7:0] byte_out
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_next;

  // Fibonacci form: the feedback bit is both the emitted bit and the new LSB.
  always_comb begin
    logic [6:0] s;
    logic       fb;
    s        = lfsr_q;
    byte_out = '0;
    for (int i = 0; i < 8; i++) begin
      fb            = ^(s & PRBS_TAPS);
      byte_out[7-i] = fb;
      s             = {s[5:0], fb};
    end
    lfsr_next = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= PRBS_SEED;
    end else if (seed_load) begin
      lfsr_q <= PRBS_SEED;
    end else if (advance) begin
      lfsr_q <= lfsr_next;
    end
  end

endmodule

// File: rtl/eth_frame_gen.sv
// AXI-Stream Ethernet frame source for the tx_axis sink of a 1G MAC.
// Each frame is a 14-byte header (dst MAC, src MAC, EtherType, MSB first)
// followed by a generated payload; the MAC appends padding and FCS.
// Configuration is latched at every frame start; enable is only looked at
// on frame boundaries, so a frame always completes once started.
// Optional build macro: ETH_FRAME_GEN_PRBS_EN adds input payload_prbs,
// selecting a PRBS-7 payload (seed 7'h7F per frame) instead of the
// incrementing byte pattern.
// Ports:
//   clk, rst_n     : MAC gtx_clk, asynchronous active-low reset
//   enable         : run request
//   dst_mac/src_mac/ethertype/payload_len/gap_cycles : frame configuration
//   m_axis_*       : AXI-Stream master (tuser tied 0)
//   busy           : FSM not idle
//   frames_sent    : frames completed (tlast handshakes)
//   bytes_sent     : bytes accepted by the sink
module eth_frame_gen
  import eth_frame_gen_pkg::*;
#(
  parameter int C_MAX_PAYLOAD = 1500,
  parameter int C_GAP_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [47:0]            dst_mac,
  input  logic [47:0]            src_mac,
  input  logic [15:0]            ethertype,
  input  logic [15:0]            payload_len,
  input  logic [C_GAP_WIDTH-1:0] gap_cycles,
`ifdef ETH_FRAME_GEN_PRBS_EN
  input  logic                   payload_prbs,
`endif
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  input  logic                   m_axis_tready,
  output logic                   busy,
  output logic [31:0]            frames_sent,
  output logic [63:0]            bytes_sent
);

  state_t                 state_q, state_d;
  frame_cfg_t             cfg_q, cfg_d;
  logic [C_GAP_WIDTH-1:0] gap_q, gap_d;
  logic [C_GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]            idx_q, idx_d;
  logic [7:0]             tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [31:0]            frames_q, frames_d;
  logic [63:0]            bytes_q, bytes_d;

  logic                   xfer;
  logic                   start_frame;
  logic [7:0]             pay_byte_next;
  logic [7:0]             inc_byte_next;

  assign xfer = tvalid_q && m_axis_tready;

  // Next payload byte to load into the output register: byte 0 when leaving
  // the header, otherwise the byte after the one currently presented.
  assign inc_byte_next = (state_q == ST_HEADER) ? 8'd0 : idx_q[7:0] + 8'd1;

`ifdef ETH_FRAME_GEN_PRBS_EN
  logic       prbs_q;
  logic [7:0] prbs_byte;
  logic       prbs_advance;

  // The LFSR always holds the byte that will be loaded next, so it steps
  // exactly when a payload byte is loaded into tdata.
  assign prbs_advance = xfer &&
                        ((state_q == ST_HEADER && idx_q == 16'(HDR_LEN - 1)) ||
                         (state_q == ST_PAYLOAD && !tlast_q));

  eth_prbs7_byte u_prbs (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (start_frame),
    .advance   (prbs_advance),
    .byte_out  (prbs_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prbs_q <= 1'b0;
    end else if (start_frame) begin
      prbs_q <= payload_prbs;
    end
  end

  assign pay_byte_next = prbs_q ? prbs_byte : inc_byte_next;
`else
  assign pay_byte_next = inc_byte_next;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first; a path that skips an
    // assignment would otherwise infer a latch.
    state_d     = state_q;
    cfg_d       = cfg_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    idx_d       = idx_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    frames_d    = frames_q;
    bytes_d     = bytes_q;
    start_frame = 1'b0;

    if (xfer) begin
      bytes_d = bytes_q + 64'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        start_frame = enable;
      end

      ST_HEADER: begin
        if (xfer) begin
          if (idx_q == 16'(HDR_LEN - 1)) begin
            state_d = ST_PAYLOAD;
            idx_d   = '0;
            tdata_d = pay_byte_next;
            tlast_d = (cfg_q.len == 16'd1);
          end else begin
            idx_d   = idx_q + 16'd1;
            tdata_d = hdr_byte(cfg_q, idx_q[3:0] + 4'd1);
          end
        end
      end

      ST_PAYLOAD: begin
        if (xfer) begin
          if (tlast_q) begin
            frames_d = frames_q + 32'd1;
            tlast_d  = 1'b0;
            if (gap_q != '0) begin
              state_d   = ST_GAP;
              tvalid_d  = 1'b0;
              gap_cnt_d = gap_q;
            end else if (enable) begin
              start_frame = 1'b1;
            end else begin
              state_d  = ST_IDLE;
              tvalid_d = 1'b0;
            end
          end else begin
            idx_d   = idx_q + 16'd1;
            tdata_d = pay_byte_next;
            tlast_d = ((idx_q + 16'd1) == (cfg_q.len - 16'd1));
          end
        end
      end

      ST_GAP: begin
        // gap_cnt counts the idle cycles still to come, including this one.
        if (gap_cnt_q > C_GAP_WIDTH'(1)) begin
          gap_cnt_d = gap_cnt_q - C_GAP_WIDTH'(1);
        end else if (enable) begin
          start_frame = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Frame start: latch config and present dst byte 0 on the next cycle.
    if (start_frame) begin
      cfg_d.dst       = dst_mac;
      cfg_d.src       = src_mac;
      cfg_d.ethertype = ethertype;
      cfg_d.len       = clamp_len(payload_len, C_MAX_PAYLOAD);
      gap_d           = gap_cycles;
      state_d         = ST_HEADER;
      idx_d           = '0;
      tdata_d         = dst_mac[47:40];
      tvalid_d        = 1'b1;
      tlast_d         = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of process evaluation order.
  // NOTE: every register here, including the latched config, is reset so the
  // outputs are all zero the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      idx_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      frames_q  <= '0;
      bytes_q   <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      idx_q     <= idx_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      frames_q  <= frames_d;
      bytes_q   <= bytes_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = 1'b0;
  assign busy          = (state_q != ST_IDLE);
  assign frames_sent   = frames_q;
  assign bytes_sent    = bytes_q;

endmodule
